// File: rtl/upower_alu_arbiter_if.sv
// Requester-side bus of the uPOWER ALU arbiter: two operation request
// channels with a shared valid/ready pair and the per-requester response.
interface upower_alu_arbiter_if #(
    parameter int WIDTH = 64
);
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [1:0]       req_aluop0;
    logic [1:0]       req_aluop1;
    logic [5:0]       req_opcode0;
    logic [5:0]       req_opcode1;
    logic [8:0]       req_xo0;
    logic [8:0]       req_xo1;
    logic [WIDTH-1:0] req_a0;
    logic [WIDTH-1:0] req_b0;
    logic [WIDTH-1:0] req_a1;
    logic [WIDTH-1:0] req_b1;
    logic [1:0]       rsp_valid;
    logic [1:0]       rsp_ready;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_overflow;
    logic             rsp_zero;

    // Requester side: presents operations, consumes responses.
    modport master (
        output req_valid, req_aluop0, req_aluop1, req_opcode0, req_opcode1,
               req_xo0, req_xo1, req_a0, req_b0, req_a1, req_b1, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_overflow, rsp_zero
    );

    // Arbiter side.
    modport slave (
        input  req_valid, req_aluop0, req_aluop1, req_opcode0, req_opcode1,
               req_xo0, req_xo1, req_a0, req_b0, req_a1, req_b1, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_overflow, rsp_zero
    );
endinterface

// File: rtl/upower_alu_arbiter.sv
// Round-robin sequencer sharing one combinational 64-bit ALU between two
// requesters. One operation is in flight at a time: IDLE arbitrates and
// latches operands, EXEC lets the ALU settle for one cycle, RESP holds the
// captured result until the granted requester takes it.
module upower_alu_arbiter #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    upower_alu_arbiter_if.slave bus,
    output logic [1:0]       alu_aluop,
    output logic [5:0]       alu_opcode,
    output logic [8:0]       alu_xo,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_overflow,
    input  logic             alu_zero,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    // last_grant resets to 1 so that requester 0 wins the first tie.
    logic       last_grant;
    logic       grant_id;
    logic       arb_sel;
    logic       accept;
    logic       release_rsp;
    logic [1:0] ready_int;
    logic [1:0] rsp_vld;

    // Operand registers feeding the ALU (stage 0) and captured response (stage 1).
    logic [1:0]       aluop_p0;
    logic [5:0]       opcode_p0;
    logic [8:0]       xo_p0;
    logic [WIDTH-1:0] a_p0;
    logic [WIDTH-1:0] b_p0;
    logic [WIDTH-1:0] result_p1;
    logic             overflow_p1;
    logic             zero_p1;

    // Round-robin pick: a lone requester wins; on contention the one not served last.
    always_comb begin
        arb_sel   = 1'b0;
        ready_int = 2'b00;
        case (bus.req_valid)
            2'b01:   arb_sel = 1'b0;
            2'b10:   arb_sel = 1'b1;
            2'b11:   arb_sel = ~last_grant;
            default: arb_sel = 1'b0;
        endcase
        // Ready is only offered while idle, out of reset, and to a requester that is asking.
        if (state == IDLE && rst_n && bus.req_valid[arb_sel]) begin
            ready_int[arb_sel] = 1'b1;
        end
    end

    assign bus.req_ready = ready_int;
    assign accept        = |ready_int;
    assign release_rsp   = (state == RESP) && bus.rsp_ready[grant_id];

    // Next-state decode; EXEC always lasts exactly one cycle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = EXEC;
            EXEC:    state_next = RESP;
            RESP:    if (release_rsp) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Response valid points only at the requester that owns the operation.
    always_comb begin
        rsp_vld = 2'b00;
        if (state == RESP) begin
            rsp_vld[grant_id] = 1'b1;
        end
    end

    assign bus.rsp_valid    = rsp_vld;
    assign bus.rsp_result   = result_p1;
    assign bus.rsp_overflow = overflow_p1;
    assign bus.rsp_zero     = zero_p1;
    assign busy             = (state != IDLE);

    assign alu_aluop  = aluop_p0;
    assign alu_opcode = opcode_p0;
    assign alu_xo     = xo_p0;
    assign alu_a      = a_p0;
    assign alu_b      = b_p0;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Stage 0: latch the winner's operation on the request handshake; held otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aluop_p0  <= '0;
            opcode_p0 <= '0;
            xo_p0     <= '0;
            a_p0      <= '0;
            b_p0      <= '0;
            grant_id  <= 1'b0;
        end else if (accept) begin
            grant_id <= arb_sel;
            if (arb_sel) begin
                aluop_p0  <= bus.req_aluop1;
                opcode_p0 <= bus.req_opcode1;
                xo_p0     <= bus.req_xo1;
                a_p0      <= bus.req_a1;
                b_p0      <= bus.req_b1;
            end else begin
                aluop_p0  <= bus.req_aluop0;
                opcode_p0 <= bus.req_opcode0;
                xo_p0     <= bus.req_xo0;
                a_p0      <= bus.req_a0;
                b_p0      <= bus.req_b0;
            end
        end
    end

    // Stage 1: capture the settled ALU outputs on the edge that ends EXEC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_p1   <= '0;
            overflow_p1 <= 1'b0;
            zero_p1     <= 1'b0;
        end else if (state == EXEC) begin
            result_p1   <= alu_result;
            overflow_p1 <= alu_overflow;
            zero_p1     <= alu_zero;
        end
    end

    // Fairness history is updated only once a response has actually been consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
        end else if (release_rsp) begin
            last_grant <= grant_id;
        end
    end

    a_ready_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(bus.req_ready));
    a_ready_idle_only: assert property (@(posedge clk) disable iff (!rst_n)
        (state != IDLE) |-> (bus.req_ready == 2'b00));
    a_rsp_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(bus.rsp_valid));

endmodule

// File: tb/tb_upower_alu_arbiter.sv
// Bench for upower_alu_arbiter: a behavioural uPOWER ALU closes the loop,
// directed scenarios cover the documented cases and a randomized run is
// scored against a transaction-level round-robin model.
module tb_upower_alu_arbiter;
    localparam int WIDTH = 64;
    localparam logic [8:0] XO_AND  = 9'd28;
    localparam logic [8:0] XO_OR   = 9'd444;
    localparam logic [8:0] XO_ADD  = 9'd266;
    localparam logic [8:0] XO_SUBF = 9'd40;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    upower_alu_arbiter_if #(.WIDTH(WIDTH)) bus ();

    logic [1:0]       alu_aluop;
    logic [5:0]       alu_opcode;
    logic [8:0]       alu_xo;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [WIDTH-1:0] alu_result;
    logic             alu_overflow;
    logic             alu_zero;
    logic             busy;

    int checks   = 0;
    int failures = 0;

    upower_alu_arbiter #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus.slave),
        .alu_aluop   (alu_aluop),
        .alu_opcode  (alu_opcode),
        .alu_xo      (alu_xo),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_result  (alu_result),
        .alu_overflow(alu_overflow),
        .alu_zero    (alu_zero),
        .busy        (busy)
    );

    // Behavioural ALU: X-form ops under ALUOp=10/OpCode=31, plain add/sub otherwise.
    function automatic logic [63:0] f_res(input logic [1:0] op, input logic [5:0] opc,
                                          input logic [8:0] xo, input logic [63:0] a,
                                          input logic [63:0] b);
        if (op == 2'b10 && opc == 6'd31) begin
            case (xo)
                XO_AND:  return a & b;
                XO_OR:   return a | b;
                XO_ADD:  return a + b;
                XO_SUBF: return a - b;
                default: return a ^ b;
            endcase
        end
        if (op == 2'b00) return a + b;
        if (op == 2'b01) return a - b;
        return a ^ b;
    endfunction

    function automatic logic f_ovf(input logic [1:0] op, input logic [5:0] opc,
                                   input logic [8:0] xo, input logic [63:0] a,
                                   input logic [63:0] b);
        logic [63:0] r;
        logic        is_add;
        logic        is_sub;
        r      = f_res(op, opc, xo, a, b);
        is_add = (op == 2'b00) || (op == 2'b10 && opc == 6'd31 && xo == XO_ADD);
        is_sub = (op == 2'b01) || (op == 2'b10 && opc == 6'd31 && xo == XO_SUBF);
        if (is_add) return (a[63] == b[63]) && (r[63] != a[63]);
        if (is_sub) return (a[63] != b[63]) && (r[63] != a[63]);
        return 1'b0;
    endfunction

    assign alu_result   = f_res(alu_aluop, alu_opcode, alu_xo, alu_a, alu_b);
    assign alu_overflow = f_ovf(alu_aluop, alu_opcode, alu_xo, alu_a, alu_b);
    assign alu_zero     = (alu_result == '0);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int r, input logic [1:0] op, input logic [5:0] opc,
                          input logic [8:0] xo, input logic [63:0] a, input logic [63:0] b);
        if (r == 0) begin
            bus.req_aluop0 = op; bus.req_opcode0 = opc; bus.req_xo0 = xo;
            bus.req_a0 = a; bus.req_b0 = b;
        end else begin
            bus.req_aluop1 = op; bus.req_opcode1 = opc; bus.req_xo1 = xo;
            bus.req_a1 = a; bus.req_b1 = b;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.req_valid = 2'b00;
        bus.rsp_ready = 2'b00;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    // Issue a lone request on requester r and advance to RESP.
    task automatic issue(input int r);
        bus.req_valid = (r == 0) ? 2'b01 : 2'b10;
        tick();
        bus.req_valid = 2'b00;
        tick();
    endtask

    task automatic finish_rsp(input int r);
        bus.rsp_ready = (r == 0) ? 2'b01 : 2'b10;
        tick();
        bus.rsp_ready = 2'b00;
    endtask

    task automatic test_reset();
        set_op(0, 2'b00, 6'd0, 9'd0, 64'd0, 64'd0);
        set_op(1, 2'b00, 6'd0, 9'd0, 64'd0, 64'd0);
        rst_n = 1'b0;
        bus.req_valid = 2'b00;
        bus.rsp_ready = 2'b00;
        tick();
        tick();
        checks++;
        if ({busy, bus.rsp_valid, bus.req_ready} !== 5'b0) begin
            failures++;
            $display("FAIL reset_ctrl: busy/rsp_valid/req_ready=%b required 00000",
                     {busy, bus.rsp_valid, bus.req_ready});
        end
        checks++;
        if ({alu_aluop, alu_opcode, alu_xo, alu_a, alu_b} !== '0) begin
            failures++;
            $display("FAIL reset_alu: a=%h b=%h op=%b opc=%b xo=%b required all 0",
                     alu_a, alu_b, alu_aluop, alu_opcode, alu_xo);
        end
        checks++;
        if ({bus.rsp_result, bus.rsp_overflow, bus.rsp_zero} !== '0) begin
            failures++;
            $display("FAIL reset_rsp: result=%h ovf=%b zero=%b required 0",
                     bus.rsp_result, bus.rsp_overflow, bus.rsp_zero);
        end
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_single();
        set_op(0, 2'b10, 6'b011111, 9'b000011100, 64'h101, 64'h11);
        bus.req_valid = 2'b01;
        #1;
        checks++;
        if (bus.req_ready !== 2'b01) begin
            failures++;
            $display("FAIL single_ready: req_ready=%b required 01", bus.req_ready);
        end
        tick();
        bus.req_valid = 2'b00;
        #1;
        checks++;
        if ({busy, bus.rsp_valid, alu_a, alu_b} !== {1'b1, 2'b00, 64'h101, 64'h11}) begin
            failures++;
            $display("FAIL single_exec: busy=%b rsp_valid=%b a=%h b=%h required 1 00 101 11",
                     busy, bus.rsp_valid, alu_a, alu_b);
        end
        tick();
        checks++;
        if ({bus.rsp_valid, bus.rsp_result, bus.rsp_zero} !== {2'b01, 64'h1, 1'b0}) begin
            failures++;
            $display("FAIL single_rsp: rsp_valid=%b result=%h zero=%b required 01 1 0",
                     bus.rsp_valid, bus.rsp_result, bus.rsp_zero);
        end
        finish_rsp(0);
        #1;
        checks++;
        if ({busy, bus.rsp_valid} !== 3'b000) begin
            failures++;
            $display("FAIL single_done: busy=%b rsp_valid=%b required 0 00", busy, bus.rsp_valid);
        end
    endtask

    task automatic test_backpressure();
        set_op(1, 2'b10, 6'd31, 9'b100001010, 64'hA, 64'h1);
        bus.req_valid = 2'b10;
        #1;
        checks++;
        if (bus.req_ready !== 2'b10) begin
            failures++;
            $display("FAIL bp_ready: req_ready=%b required 10", bus.req_ready);
        end
        tick();
        bus.req_valid = 2'b00;
        tick();
        for (int i = 0; i < 4; i++) begin
            // Ready on the non-granted bit must not release the response.
            bus.rsp_ready = (i % 2 == 1) ? 2'b01 : 2'b00;
            #1;
            checks++;
            if ({bus.rsp_valid, bus.rsp_result, busy} !== {2'b10, 64'hB, 1'b1}) begin
                failures++;
                $display("FAIL bp_hold cycle %0d: rsp_valid=%b result=%h busy=%b required 10 b 1",
                         i, bus.rsp_valid, bus.rsp_result, busy);
            end
            tick();
        end
        finish_rsp(1);
        #1;
        checks++;
        if ({busy, bus.rsp_valid} !== 3'b000) begin
            failures++;
            $display("FAIL bp_release: busy=%b rsp_valid=%b required 0 00", busy, bus.rsp_valid);
        end
    endtask

    task automatic test_contention();
        int cnt;
        logic [1:0] exp;
        do_reset();
        set_op(0, 2'b10, 6'd31, XO_AND, 64'hF0F0, 64'hFF00);
        set_op(1, 2'b10, 6'd31, XO_OR, 64'h1010000000000000, 64'h1100000000000000);
        bus.req_valid = 2'b11;
        bus.rsp_ready = 2'b11;
        #1;
        for (int k = 0; k < 4; k++) begin
            exp = (k % 2 == 0) ? 2'b01 : 2'b10;
            cnt = 0;
            while (bus.req_ready == 2'b00 && cnt < 10) begin
                tick();
                cnt++;
            end
            checks++;
            if (bus.req_ready !== exp) begin
                failures++;
                $display("FAIL contention_grant %0d: req_ready=%b required %b", k, bus.req_ready, exp);
            end
            tick();
            tick();
            checks++;
            if ({bus.rsp_valid, bus.rsp_result} !==
                {exp, (k % 2 == 0) ? 64'hF000 : 64'h1110000000000000}) begin
                failures++;
                $display("FAIL contention_rsp %0d: rsp_valid=%b result=%h", k, bus.rsp_valid,
                         bus.rsp_result);
            end
            tick();
        end
        bus.req_valid = 2'b00;
        bus.rsp_ready = 2'b00;
        #1;
    endtask

    task automatic test_flags();
        set_op(0, 2'b10, 6'd31, XO_ADD, 64'h7FFFFFFFFFFFFFFF, 64'h1);
        issue(0);
        checks++;
        if ({bus.rsp_overflow, bus.rsp_zero, bus.rsp_result} !== {2'b10, 64'h8000000000000000}) begin
            failures++;
            $display("FAIL flag_ovf: ovf=%b zero=%b result=%h required 1 0 8000000000000000",
                     bus.rsp_overflow, bus.rsp_zero, bus.rsp_result);
        end
        finish_rsp(0);
        set_op(1, 2'b10, 6'd31, XO_SUBF, 64'd7, 64'd7);
        issue(1);
        checks++;
        if ({bus.rsp_overflow, bus.rsp_zero, bus.rsp_result} !== {2'b01, 64'h0}) begin
            failures++;
            $display("FAIL flag_zero: ovf=%b zero=%b result=%h required 0 1 0",
                     bus.rsp_overflow, bus.rsp_zero, bus.rsp_result);
        end
        finish_rsp(1);
    endtask

    task automatic test_input_change();
        set_op(0, 2'b10, 6'd31, XO_SUBF, 64'd7, 64'd1);
        bus.req_valid = 2'b01;
        tick();
        bus.req_a0  = 64'hFF;
        bus.req_xo0 = XO_OR;
        #1;
        checks++;
        if (bus.req_ready !== 2'b00) begin
            failures++;
            $display("FAIL change_exec_ready: req_ready=%b required 00", bus.req_ready);
        end
        tick();
        checks++;
        if ({bus.rsp_valid, bus.rsp_result, bus.req_ready} !== {2'b01, 64'h6, 2'b00}) begin
            failures++;
            $display("FAIL change_rsp: rsp_valid=%b result=%h req_ready=%b required 01 6 00",
                     bus.rsp_valid, bus.rsp_result, bus.req_ready);
        end
        bus.req_valid = 2'b00;
        finish_rsp(0);
    endtask

    task automatic test_reset_midop();
        // Complete one op for requester 0 so the history favours requester 1.
        set_op(0, 2'b00, 6'd0, 9'd0, 64'd3, 64'd4);
        issue(0);
        finish_rsp(0);
        set_op(1, 2'b00, 6'd0, 9'd0, 64'd5, 64'd6);
        issue(1);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.rsp_valid, busy, bus.rsp_result, alu_a} !== '0) begin
            failures++;
            $display("FAIL midop_reset: rsp_valid=%b busy=%b result=%h alu_a=%h required 0",
                     bus.rsp_valid, busy, bus.rsp_result, alu_a);
        end
        tick();
        rst_n = 1'b1;
        bus.req_valid = 2'b11;
        #1;
        checks++;
        if (bus.req_ready !== 2'b01) begin
            failures++;
            $display("FAIL midop_first_grant: req_ready=%b required 01", bus.req_ready);
        end
        tick();
        bus.req_valid = 2'b00;
        tick();
        checks++;
        if ({bus.rsp_valid, bus.rsp_result} !== {2'b01, 64'd7}) begin
            failures++;
            $display("FAIL midop_after: rsp_valid=%b result=%h required 01 7",
                     bus.rsp_valid, bus.rsp_result);
        end
        finish_rsp(0);
    endtask

    task automatic rand_op(input int r);
        logic [1:0]  op;
        logic [8:0]  xo;
        logic [63:0] a;
        logic [63:0] b;
        int sel;
        sel = $urandom_range(0, 5);
        op  = 2'b10;
        case (sel)
            0: xo = XO_AND;
            1: xo = XO_OR;
            2: xo = XO_ADD;
            3: xo = XO_SUBF;
            4: xo = 9'($urandom);
            default: begin xo = XO_ADD; op = 2'($urandom_range(0, 3)); end
        endcase
        a = {$urandom, $urandom};
        b = ($urandom_range(0, 3) == 0) ? a : {$urandom, $urandom};
        if ($urandom_range(0, 4) == 0) a = 64'h7FFFFFFFFFFFFFFF;
        set_op(r, op, 6'd31, xo, a, b);
    endtask

    task automatic test_random();
        int lg;
        int g;
        int waits;
        logic [1:0]  v;
        logic [1:0]  g_hot;
        logic [63:0] er;
        logic        eo;
        do_reset();
        lg = 1;
        for (int t = 0; t < 40; t++) begin
            for (int n = $urandom_range(0, 2); n > 0; n--) begin
                bus.req_valid = 2'b00;
                #1;
                checks++;
                if ({bus.req_ready, busy} !== 3'b000) begin
                    failures++;
                    $display("FAIL rand_idle %0d: req_ready=%b busy=%b required 00 0",
                             t, bus.req_ready, busy);
                end
                tick();
            end
            rand_op(0);
            rand_op(1);
            v = 2'($urandom_range(1, 3));
            bus.req_valid = v;
            g = (v == 2'b11) ? 1 - lg : ((v == 2'b01) ? 0 : 1);
            g_hot = (g == 0) ? 2'b01 : 2'b10;
            if (g == 0) begin
                er = f_res(bus.req_aluop0, bus.req_opcode0, bus.req_xo0, bus.req_a0, bus.req_b0);
                eo = f_ovf(bus.req_aluop0, bus.req_opcode0, bus.req_xo0, bus.req_a0, bus.req_b0);
            end else begin
                er = f_res(bus.req_aluop1, bus.req_opcode1, bus.req_xo1, bus.req_a1, bus.req_b1);
                eo = f_ovf(bus.req_aluop1, bus.req_opcode1, bus.req_xo1, bus.req_a1, bus.req_b1);
            end
            #1;
            checks++;
            if (bus.req_ready !== g_hot) begin
                failures++;
                $display("FAIL rand_grant %0d: valid=%b req_ready=%b required %b",
                         t, v, bus.req_ready, g_hot);
            end
            tick();
            // Scramble requester inputs while the operation is in flight.
            rand_op(0);
            rand_op(1);
            bus.req_valid = 2'($urandom);
            #1;
            checks++;
            if ({busy, bus.rsp_valid, bus.req_ready} !== 5'b10000) begin
                failures++;
                $display("FAIL rand_exec %0d: busy=%b rsp_valid=%b req_ready=%b required 1 00 00",
                         t, busy, bus.rsp_valid, bus.req_ready);
            end
            tick();
            waits = $urandom_range(0, 3);
            for (int w = 0; w <= waits; w++) begin
                bus.rsp_ready = (w == waits) ? (g_hot | (~g_hot & 2'($urandom)))
                                             : (~g_hot & 2'($urandom));
                #1;
                checks++;
                if ({bus.rsp_valid, bus.rsp_result, bus.rsp_overflow, bus.rsp_zero} !==
                    {g_hot, er, eo, (er == 64'd0)}) begin
                    failures++;
                    $display("FAIL rand_rsp %0d: rsp_valid=%b result=%h ovf=%b zero=%b required %b %h %b %b",
                             t, bus.rsp_valid, bus.rsp_result, bus.rsp_overflow, bus.rsp_zero,
                             g_hot, er, eo, (er == 64'd0));
                end
                tick();
            end
            lg = g;
            bus.rsp_ready = 2'b00;
            bus.req_valid = 2'b00;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_contention();
        test_flags();
        test_input_change();
        test_reset_midop();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/upower_alu_arbiter.md
Name: upower_alu_arbiter

Overview:
- Sequencer and arbiter that shares the single 64-bit ALU, and its uPOWER ALU control unit, between two requesters, e.g. the integer-execute path and the branch/compare path.
- Accepts one operation at a time using valid/ready handshakes, with round-robin arbitration.
- Drives ALUOp, OpCode, XO and the operands from registers, then captures Result, Overflow and Zero.
- Returns the captured result to the granted requester with a valid/ready response handshake.

Parameters:
- WIDTH, 64, operand and result width; must match the ALU width.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  2  bit i: requester i presents an operation.
- req_ready  output  2  bit i: arbiter accepts requester i's operation this cycle.
- req_aluop0, req_aluop1  input  2 each  ALUOp for requester 0 / 1.
- req_opcode0, req_opcode1  input  6 each  primary OpCode.
- req_xo0, req_xo1  input  9 each  extended opcode (XO).
- req_a0, req_b0, req_a1, req_b1  input  WIDTH each  operands.
- alu_aluop  output  2  to the ALU control unit.
- alu_opcode  output  6  to the ALU control unit.
- alu_xo  output  9  to the ALU control unit.
- alu_a, alu_b  output  WIDTH  to the ALU operand inputs.
- alu_result  input  WIDTH  ALU Result (combinational).
- alu_overflow, alu_zero  input  1  ALU flags.
- rsp_valid  output  2  bit i: response for requester i is valid.
- rsp_ready  input  2  bit i: requester i consumes its response.
- rsp_result  output  WIDTH  captured result.
- rsp_overflow, rsp_zero  output  1  captured flags.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- FSM states: IDLE, EXEC, RESP.
- Reset (asynchronous, rst_n=0):
  - state=IDLE; last_grant=1, so requester 0 wins the first tie.
  - All alu_* outputs, rsp_result, rsp_overflow and rsp_zero are 0.
  - rsp_valid=0, req_ready=0, busy=0.
- Arbitration (IDLE only):
  - If exactly one req_valid bit is set, grant that requester.
  - If both are set, grant the requester that is not last_grant (strict alternation under continuous contention).
  - req_ready[g] is combinational: high only in IDLE, only for the granted g, and only while req_valid[g]=1. The other bit stays 0.
  - Handshake (req_valid[g] & req_ready[g]) latches that requester's aluop, opcode, xo, a and b into the operand registers, records g, and moves to EXEC.
- IDLE with no req_valid: stay in IDLE; alu_* outputs hold their last values.
- EXEC (exactly one cycle):
  - The registered operands drive alu_*; the ALU settles combinationally.
  - On the clock edge ending EXEC, capture alu_result, alu_overflow and alu_zero into the rsp_* registers, then move to RESP.
- RESP:
  - rsp_valid[g]=1; rsp_result, rsp_overflow and rsp_zero are stable.
  - Hold until rsp_ready[g]=1. Then clear rsp_valid, set last_grant=g, and return to IDLE.
  - rsp_ready on the non-granted bit is ignored.
- Latency: accept edge to rsp_valid high is 2 cycles. Minimum issue interval is 3 cycles, with zero response backpressure.
- Requester inputs are ignored after acceptance; changing req_* during EXEC or RESP has no effect on the captured operation.
- A req_valid deasserted before the handshake is legal; nothing is recorded.
- No req_ready is asserted in EXEC or RESP, even if req_valid is high.
- Reset asserted mid-operation (EXEC or RESP) aborts the operation: no response is delivered and all outputs return to reset values immediately.
- The arbiter does not decode ALUOp/OpCode/XO; unsupported codes pass through unchanged and the result is whatever the ALU produces.
- Flags are captured as produced by the ALU; there is no sign or width manipulation.

Test Plan:
- Reset then single op: req_valid=01, aluop=10, opcode=011111, xo=000011100, a=0x101, b=0x11.
  - Expected: req_ready=01 that cycle; rsp_valid=01 two cycles later; rsp_result=0x0000000000000001, zero=0.
- Add with backpressure: requester 1, xo=100001010, a=0xA, b=0x1, rsp_ready held 0 for 4 cycles.
  - Expected: rsp_result=0xB held stable with rsp_valid=10 throughout; returns to IDLE one cycle after rsp_ready=1.
- Contention: both req_valid high continuously after reset with distinct ops (requester 0 AND, requester 1 OR 0x1010...|0x1100...).
  - Expected: grants alternate 0,1,0,1; requester 1's result is 0x1110000000000000.
- Overflow/zero flags: add with a=0x7FFFFFFFFFFFFFFF, b=1.
  - Expected: rsp_overflow=1, rsp_result=0x8000000000000000.
  - subf with xo=000101000, a=7, b=7: expected rsp_zero=1, rsp_result=0.
- Input change after acceptance: accept subf with a=7, b=1, then change req_a0 to 0xFF during EXEC.
  - Expected: rsp_result=0x6.
- Reset mid-op: assert rst_n=0 during RESP.
  - Expected: rsp_valid=00 and busy=0 immediately.
  - After release with both requesting, requester 0 is granted first.
